cpuregs_rd_seq: RTL and testbench

CPUREGS_RD_SEQ -- requirements
Module: cpuregs_rd_seq

---
 rtl/cpuregs_pkg.sv | 16 +
 rtl/cpuregs_rd_cap.sv | 34 +++
 rtl/cpuregs_rd_seq.sv | 107 ++++++++++
 tb/tb_cpuregs_rd_seq.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpuregs_pkg.sv
// Shared definitions for the two-operand register read sequencer.
// CPUREGS_BYPASS_EN (defined elsewhere) turns on snooped write forwarding.
package cpuregs_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int ZERO_IDX       = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD1  = 2'd1,
    RD2  = 2'd2,
    RSP  = 2'd3
  } state_t;

endpackage

// File: rtl/cpuregs_rd_cap.sv
// Selects the value to capture for one register index.
// Build option CPUREGS_BYPASS_EN lets a same-cycle snooped write win over rf_do.
module cpuregs_rd_cap
  import cpuregs_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] index,
  input  logic [DATA_WIDTH-1:0] rf_do,
  input  logic                  wr_we,
  input  logic [ADDR_WIDTH-1:0] wr_waddr,
  input  logic [DATA_WIDTH-1:0] wr_di,
  output logic [DATA_WIDTH-1:0] data
);

`ifdef CPUREGS_BYPASS_EN
  always_comb begin
    data = rf_do;
    if (wr_we && (wr_waddr == index)) data = wr_di;
    // Register zero reads as zero no matter what the file or a write claims.
    if (index == ADDR_WIDTH'(ZERO_IDX)) data = '0;
  end
`else
  logic unused_wr;
  assign unused_wr = ^{wr_we, wr_waddr, wr_di};

  always_comb begin
    data = rf_do;
    if (index == ADDR_WIDTH'(ZERO_IDX)) data = '0;
  end
`endif

endmodule

// File: rtl/cpuregs_rd_seq.sv
// Sequences two register-file reads per request through one read port.
// Build option CPUREGS_BYPASS_EN forwards snooped writes into captured and held data.
module cpuregs_rd_seq
  import cpuregs_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic [ADDR_WIDTH-1:0] rf_raddr,
  input  logic [DATA_WIDTH-1:0] rf_do,
  input  logic                  wr_we,
  input  logic [ADDR_WIDTH-1:0] wr_waddr,
  input  logic [DATA_WIDTH-1:0] wr_di
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] rs1_q;
  logic [ADDR_WIDTH-1:0] rs2_q;
  logic [DATA_WIDTH-1:0] cap_data;

  // rf_raddr always points at the index being read, so it doubles as the selector index.
  cpuregs_rd_cap #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_cap (
    .index   (rf_raddr),
    .rf_do   (rf_do),
    .wr_we   (wr_we),
    .wr_waddr(wr_waddr),
    .wr_di   (wr_di),
    .data    (cap_data)
  );

`ifdef CPUREGS_BYPASS_EN
  logic hit1;
  logic hit2;
  assign hit1 = wr_we && (wr_waddr == rs1_q) && (rs1_q != ADDR_WIDTH'(ZERO_IDX));
  assign hit2 = wr_we && (wr_waddr == rs2_q) && (rs2_q != ADDR_WIDTH'(ZERO_IDX));
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rf_raddr  <= '0;
      rs1_data  <= '0;
      rs2_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            rs1_q     <= rs1;
            rs2_q     <= rs2;
            rf_raddr  <= rs1;
            req_ready <= 1'b0;
            state     <= RD1;
          end else begin
            req_ready <= 1'b1;
          end
        end
        RD1: begin
          rs1_data <= cap_data;
          if (rs2_q == rs1_q) begin
            rs2_data <= cap_data;
            state    <= RSP;
          end else begin
            rf_raddr <= rs2_q;
            state    <= RD2;
          end
        end
        RD2: begin
          rs2_data <= cap_data;
          state    <= RSP;
        end
        RSP: begin
          // rsp_valid is registered, so it rises one edge after entering RSP.
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            rsp_valid <= 1'b1;
`ifdef CPUREGS_BYPASS_EN
            if (hit1) rs1_data <= wr_di;
            if (hit2) rs2_data <= wr_di;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpuregs_rd_seq.sv
// Self-checking bench for cpuregs_rd_seq against a behavioural register-file model.
// Honours CPUREGS_BYPASS_EN when the same define is given to the bench build.
module tb_cpuregs_rd_seq;

`ifdef CPUREGS_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_do;
  logic        wr_we;
  logic [4:0]  wr_waddr;
  logic [31:0] wr_di;

  logic [31:0] regs [32];
  bit          force_ones;
  int          checks;
  int          failures;

  always #5 clk = ~clk;

  assign rf_do = force_ones ? 32'hFFFF_FFFF : regs[rf_raddr];

  cpuregs_rd_seq dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .rs1(rs1), .rs2(rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rf_raddr(rf_raddr), .rf_do(rf_do),
    .wr_we(wr_we), .wr_waddr(wr_waddr), .wr_di(wr_di)
  );

  function automatic logic [31:0] ref_read(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'd0 : (force_ones ? 32'hFFFF_FFFF : regs[idx]);
  endfunction

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    ok = req_ready;
  endtask

  // One complete request; rsp_ready is held low for 'hold' cycles once rsp_valid is seen.
  task automatic do_read(input logic [4:0] a, input logic [4:0] b, input int hold,
                         output logic [31:0] d1, output logic [31:0] d2, output int lat,
                         output logic [4:0] ad0, output logic [4:0] ad1,
                         output bit stable, output bit idle_ok, output bit timeout);
    bit ok;
    lat = 0; ad0 = '0; ad1 = '0; stable = 1'b1; idle_ok = 1'b0; timeout = 1'b0;
    d1 = '0; d2 = '0;
    wait_ready(ok);
    if (!ok) begin
      timeout = 1'b1;
      return;
    end
    req_valid = 1'b1; rs1 = a; rs2 = b; rsp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    ad0 = rf_raddr;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
      if (lat == 1) ad1 = rf_raddr;
    end
    if (!rsp_valid) begin
      timeout = 1'b1;
      return;
    end
    d1 = rs1_data; d2 = rs2_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid || rs1_data !== d1 || rs2_data !== d2 || req_ready) stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    idle_ok = !rsp_valid && req_ready;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, rsp_valid, rs1_data, rs2_data, rf_raddr} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got rdy=%b vld=%b d1=%h d2=%h raddr=%0d expected all zero",
               req_ready, rsp_valid, rs1_data, rs2_data, rf_raddr);
    end
    resetn = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ready_before_edge got=%b expected=0", req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ready_after_release got=%b expected=1", req_ready);
    end
  endtask

  task automatic test_basic();
    logic [31:0] d1, d2; logic [4:0] a0, a1; int lat; bit st, idl, to;
    regs[5] = 32'h1234_5678; regs[9] = 32'hDEAD_BEEF;
    do_read(5'd5, 5'd9, 0, d1, d2, lat, a0, a1, st, idl, to);
    checks++;
    if (to || lat !== 3) begin
      failures++;
      $display("[TB] FAIL basic_latency got=%0d timeout=%b expected=3", lat, to);
    end
    checks++;
    if (d1 !== 32'h1234_5678 || d2 !== 32'hDEAD_BEEF) begin
      failures++;
      $display("[TB] FAIL basic_data got=%h/%h expected=12345678/deadbeef", d1, d2);
    end
    checks++;
    if (a0 !== 5'd5 || a1 !== 5'd9) begin
      failures++;
      $display("[TB] FAIL basic_raddr got=%0d,%0d expected=5,9", a0, a1);
    end
    checks++;
    if (!idl) begin
      failures++;
      $display("[TB] FAIL basic_idle got vld=%b rdy=%b expected vld=0 rdy=1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_same_index();
    logic [31:0] d1, d2; logic [4:0] a0, a1; int lat; bit st, idl, to;
    regs[7] = 32'hA5A5_A5A5;
    do_read(5'd7, 5'd7, 0, d1, d2, lat, a0, a1, st, idl, to);
    checks++;
    if (to || lat !== 2) begin
      failures++;
      $display("[TB] FAIL same_latency got=%0d timeout=%b expected=2", lat, to);
    end
    checks++;
    if (d1 !== 32'hA5A5_A5A5 || d2 !== 32'hA5A5_A5A5) begin
      failures++;
      $display("[TB] FAIL same_data got=%h/%h expected=a5a5a5a5/a5a5a5a5", d1, d2);
    end
    checks++;
    if (a0 !== 5'd7 || a1 !== 5'd7) begin
      failures++;
      $display("[TB] FAIL same_raddr got=%0d,%0d expected=7,7", a0, a1);
    end
  endtask

  task automatic test_zero_index();
    logic [31:0] d1, d2; logic [4:0] a0, a1; int lat; bit st, idl, to;
    force_ones = 1'b1;
    do_read(5'd0, 5'd3, 0, d1, d2, lat, a0, a1, st, idl, to);
    force_ones = 1'b0;
    checks++;
    if (to || d1 !== 32'd0 || d2 !== 32'hFFFF_FFFF) begin
      failures++;
      $display("[TB] FAIL zero_index got=%h/%h timeout=%b expected=00000000/ffffffff", d1, d2, to);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d1, d2; logic [4:0] a0, a1; int lat; bit st, idl, to;
    regs[5] = 32'h1234_5678; regs[9] = 32'hDEAD_BEEF;
    do_read(5'd5, 5'd9, 4, d1, d2, lat, a0, a1, st, idl, to);
    checks++;
    if (to || !st) begin
      failures++;
      $display("[TB] FAIL hold_stable got stable=%b timeout=%b expected stable=1", st, to);
    end
    checks++;
    if (d1 !== 32'h1234_5678 || d2 !== 32'hDEAD_BEEF) begin
      failures++;
      $display("[TB] FAIL hold_data got=%h/%h expected=12345678/deadbeef", d1, d2);
    end
    checks++;
    if (!idl) begin
      failures++;
      $display("[TB] FAIL hold_release got vld=%b rdy=%b expected vld=0 rdy=1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_bypass();
    bit ok;
    logic [31:0] exp1, exp2;
    regs[5] = 32'h1234_5678; regs[9] = 32'hDEAD_BEEF;
    exp2 = BYPASS ? 32'h0000_0042 : 32'hDEAD_BEEF;
    exp1 = BYPASS ? 32'h0000_0077 : 32'h1234_5678;
    rsp_ready = 1'b0;
    wait_ready(ok);
    req_valid = 1'b1; rs1 = 5'd5; rs2 = 5'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    wr_we = 1'b1; wr_waddr = 5'd9; wr_di = 32'h0000_0042;
    @(posedge clk); #1;
    wr_we = 1'b0; regs[9] = 32'h0000_0042;
    @(posedge clk); #1;
    checks++;
    if (!ok || rsp_valid !== 1'b1 || rs2_data !== exp2 || rs1_data !== 32'h1234_5678) begin
      failures++;
      $display("[TB] FAIL rd2_write got vld=%b d1=%h d2=%h expected vld=1 d1=12345678 d2=%h",
               rsp_valid, rs1_data, rs2_data, exp2);
    end
    wr_we = 1'b1; wr_waddr = 5'd5; wr_di = 32'h0000_0077;
    @(posedge clk); #1;
    wr_we = 1'b0; regs[5] = 32'h0000_0077;
    checks++;
    if (rsp_valid !== 1'b1 || rs1_data !== exp1 || rs2_data !== exp2) begin
      failures++;
      $display("[TB] FAIL rsp_write got vld=%b d1=%h d2=%h expected vld=1 d1=%h d2=%h",
               rsp_valid, rs1_data, rs2_data, exp1, exp2);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bypass_release got vld=%b rdy=%b expected vld=0 rdy=1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    bit ok, quiet;
    logic [31:0] d1, d2; logic [4:0] a0, a1; int lat; bit st, idl, to;
    regs[5] = 32'h1234_5678; regs[9] = 32'hDEAD_BEEF;
    rsp_ready = 1'b1;
    wait_ready(ok);
    req_valid = 1'b1; rs1 = 5'd5; rs2 = 5'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    checks++;
    if (!ok || {req_ready, rsp_valid, rs1_data, rs2_data, rf_raddr} !== '0) begin
      failures++;
      $display("[TB] FAIL midop_reset got rdy=%b vld=%b d1=%h d2=%h raddr=%0d expected all zero",
               req_ready, rsp_valid, rs1_data, rs2_data, rf_raddr);
    end
    quiet = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) quiet = 1'b0;
    end
    resetn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (!quiet || req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midop_recover got quiet=%b rdy=%b expected quiet=1 rdy=1", quiet, req_ready);
    end
    do_read(5'd9, 5'd5, 0, d1, d2, lat, a0, a1, st, idl, to);
    checks++;
    if (to || lat !== 3 || d1 !== 32'hDEAD_BEEF || d2 !== 32'h1234_5678) begin
      failures++;
      $display("[TB] FAIL midop_next got lat=%0d d=%h/%h expected lat=3 d=deadbeef/12345678", lat, d1, d2);
    end
  endtask

  task automatic test_random();
    logic [31:0] d1, d2, e1, e2; logic [4:0] a0, a1, a, b; int lat, hold, elat; bit st, idl, to;
    for (int i = 0; i < 32; i++) regs[i] = $urandom();
    for (int n = 0; n < 40; n++) begin
      a = 5'($urandom_range(0, 31));
      b = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
      hold = $urandom_range(0, 3);
      e1 = ref_read(a); e2 = ref_read(b);
      elat = (a == b) ? 2 : 3;
      do_read(a, b, hold, d1, d2, lat, a0, a1, st, idl, to);
      checks++;
      if (to || lat !== elat || d1 !== e1 || d2 !== e2 || !st || !idl || a0 !== a) begin
        failures++;
        $display("[TB] FAIL random_%0d rs=%0d,%0d got lat=%0d d=%h/%h st=%b idle=%b raddr=%0d expected lat=%0d d=%h/%h",
                 n, a, b, lat, d1, d2, st, idl, a0, elat, e1, e2);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0; force_ones = 1'b0;
    req_valid = 1'b0; rs1 = '0; rs2 = '0; rsp_ready = 1'b1;
    wr_we = 1'b0; wr_waddr = '0; wr_di = '0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0101_0101 * i;
    test_reset();
    test_basic();
    test_same_index();
    test_zero_index();
    test_backpressure();
    test_bypass();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

endmodule
